// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver, 16x oversampling with 3-sample majority vote
// Define UART_RX_PARITY_EN to expect one even-parity bit between data bit 7 and stop.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       uart_state
);

  // Divisor table is tuned for a 50 MHz clock.
  localparam int SCALE = CLK_FREQ / 50_000_000;
  localparam logic [8:0] DIV_9600   = 9'(325 * SCALE - 1);
  localparam logic [8:0] DIV_19200  = 9'(163 * SCALE - 1);
  localparam logic [8:0] DIV_38400  = 9'(81 * SCALE - 1);
  localparam logic [8:0] DIV_57600  = 9'(54 * SCALE - 1);
  localparam logic [8:0] DIV_115200 = 9'(27 * SCALE - 1);
  localparam logic [3:0] SUB_VOTE   = 4'd9;
  localparam logic [3:0] SUB_LAST   = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state_q;
  logic       sync1_q, sync2_q, dly_q;
  logic [2:0] baud_q;
  logic [8:0] div_q;
  logic [8:0] div_lim;
  logic [3:0] sub_q;
  logic [2:0] smp_q;
  logic [2:0] bit_q;
  logic [7:0] shadow_q;
  logic [7:0] data_q;
  logic       rx_done_q, frame_err_q, busy_q;
  logic       fall, tick, vote;

  assign fall = dly_q & ~sync2_q;
  assign tick = (div_q == div_lim);
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_comb begin
    div_lim = DIV_9600;
    case (baud_q)
      3'd1:    div_lim = DIV_19200;
      3'd2:    div_lim = DIV_38400;
      3'd3:    div_lim = DIV_57600;
      3'd4:    div_lim = DIV_115200;
      default: div_lim = DIV_9600;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, parity_err_q, perr;
  assign perr       = ^{shadow_q, par_q};
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      dly_q       <= 1'b1;
      baud_q      <= 3'd0;
      div_q       <= 9'd0;
      sub_q       <= 4'd0;
      smp_q       <= 3'b111;
      bit_q       <= 3'd0;
      shadow_q    <= 8'h00;
      data_q      <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      dly_q       <= sync2_q;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (state_q == S_IDLE) begin
        // Holding the counters at zero in IDLE clears them on start detection.
        div_q <= 9'd0;
        sub_q <= 4'd0;
        if (fall) begin
          state_q <= S_START;
          busy_q  <= 1'b1;
          baud_q  <= baud_set;
        end
      end else begin
        if (tick) begin
          div_q <= 9'd0;
          sub_q <= sub_q + 4'd1;
          if (sub_q >= 4'd6 && sub_q <= 4'd8) smp_q <= {smp_q[1:0], sync2_q};
        end else begin
          div_q <= div_q + 9'd1;
        end
        case (state_q)
          S_START: begin
            if (tick && sub_q == SUB_VOTE && vote) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (tick && sub_q == SUB_LAST) begin
              state_q <= S_DATA;
              bit_q   <= 3'd0;
            end
          end
          S_DATA: begin
            if (tick && sub_q == SUB_VOTE) begin
              shadow_q <= {vote, shadow_q[7:1]};
            end else if (tick && sub_q == SUB_LAST) begin
              bit_q <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (bit_q == 3'd7) state_q <= S_PARITY;
`else
              if (bit_q == 3'd7) state_q <= S_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick && sub_q == SUB_VOTE) par_q <= vote;
            else if (tick && sub_q == SUB_LAST) state_q <= S_STOP;
          end
`endif
          S_STOP: begin
            // Leave at the vote point so a start bit right after stop is caught.
            if (tick && sub_q == SUB_VOTE) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              frame_err_q <= ~vote;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= perr;
              if (vote && !perr) begin
                data_q    <= shadow_q;
                rx_done_q <= 1'b1;
              end
`else
              if (vote) begin
                data_q    <= shadow_q;
                rx_done_q <= 1'b1;
              end
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_byte  = data_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign uart_state = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - self-checking bench for uart_byte_rx
`timescale 1ns/1ps
module tb_uart_byte_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] baud_set;
  logic       uart_rx;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, parity_err, uart_state;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_ferr = 0, n_perr = 0, n_both = 0;
  int run = 0, last_run = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_byte = 8'h00;

  always #10 clk = ~clk;

  uart_byte_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .uart_state(uart_state)
  );

  always @(negedge clk) begin
    if (rx_done) begin
      n_done <= n_done + 1;
      rxq.push_back(data_byte);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (rx_done && frame_err) n_both <= n_both + 1;
    if (uart_state) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  // Nominal bit length in clocks from the line rate itself.
  function automatic int bit_clk(input int b);
    case (b)
      1:       return 50_000_000 / 19200;
      2:       return 50_000_000 / 38400;
      3:       return 50_000_000 / 57600;
      4:       return 50_000_000 / 115200;
      default: return 50_000_000 / 9600;
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int got, input int lo, input int hi);
    total++;
    assert (got >= lo && got <= hi)
    else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bc, input bit glitch);
    uart_rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (glitch) begin
        repeat (bc / 2 - 5) @(negedge clk);
        uart_rx = ~b[i];
        repeat (10) @(negedge clk);
        uart_rx = b[i];
        repeat (bc - bc / 2 - 5) @(negedge clk);
      end else begin
        repeat (bc) @(negedge clk);
      end
    end
    uart_rx = stop;
    repeat (bc) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] b, input logic stop,
                          input int baud, input bit glitch, input int sw_baud);
    int d0, f0, bc;
    bc = bit_clk(baud);
    baud_set = 3'(baud);
    d0 = n_done;
    f0 = n_ferr;
    fork
      send_frame(b, stop, bc, glitch);
      if (sw_baud >= 0) begin
        repeat (bc + bc / 2) @(negedge clk);
        baud_set = 3'(sw_baud);
      end
    join
    repeat (20) @(negedge clk);
    check({tag, ":done"}, n_done - d0, stop ? 1 : 0);
    check({tag, ":ferr"}, n_ferr - f0, stop ? 0 : 1);
    check({tag, ":byte"}, data_byte, stop ? b : exp_byte);
    if (stop) exp_byte = b;
    check_rng({tag, ":busy_len"}, last_run, bc * 77 / 8 - bc / 8, bc * 77 / 8 + bc / 8);
    check({tag, ":state"}, uart_state, 0);
  endtask

  task automatic false_start(input string tag, input int baud, input int low_clks);
    int d0, f0, bc;
    bc = bit_clk(baud);
    baud_set = 3'(baud);
    d0 = n_done;
    f0 = n_ferr;
    uart_rx = 1'b0;
    repeat (low_clks) @(negedge clk);
    uart_rx = 1'b1;
    repeat (bc) @(negedge clk);
    check({tag, ":done"}, n_done - d0, 0);
    check({tag, ":ferr"}, n_ferr - f0, 0);
    check({tag, ":state"}, uart_state, 0);
    check_rng({tag, ":busy_len"}, last_run, bc * 10 / 16 - bc / 16, bc * 10 / 16 + bc / 16);
  endtask

  initial begin
    int d0, f0, bc;
    logic [7:0] b;
    reset_n  = 1'b0;
    uart_rx  = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(negedge clk);
    check("rst:data", data_byte, 0);
    check("rst:done", rx_done, 0);
    check("rst:ferr", frame_err, 0);
    check("rst:perr", parity_err, 0);
    check("rst:state", uart_state, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    rx_frame("aa", 8'hAA, 1'b1, 4, 1'b0, -1);
    false_start("fs4", 4, 100);
    false_start("fs0", 0, 1000);
    false_start("fs7", 7, 1000);
    rx_frame("ferr3c", 8'h3C, 1'b0, 4, 1'b0, -1);

    bc = bit_clk(4);
    baud_set = 3'd4;
    d0 = n_done;
    f0 = n_ferr;
    rxq.delete();
    send_frame(8'h01, 1'b1, bc, 1'b0);
    send_frame(8'hFE, 1'b1, bc, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b:done", n_done - d0, 2);
    check("b2b:ferr", n_ferr - f0, 0);
    check("b2b:first", rxq.size() > 0 ? int'(rxq[0]) : -1, 8'h01);
    check("b2b:second", rxq.size() > 1 ? int'(rxq[1]) : -1, 8'hFE);
    exp_byte = 8'hFE;

    rx_frame("latch", 8'hC3, 1'b1, 4, 1'b0, 3);

    b = 8'h5A;
    d0 = n_done;
    f0 = n_ferr;
    uart_rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      repeat (bc) @(negedge clk);
    end
    uart_rx = b[4];
    repeat (bc / 2) @(negedge clk);
    check("midrst:busy", uart_state, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst:data", data_byte, 0);
    check("midrst:state", uart_state, 0);
    check("midrst:done", rx_done, 0);
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    reset_n = 1'b1;
    exp_byte = 8'h00;
    repeat (2 * bc) @(negedge clk);
    check("midrst:nodone", n_done - d0, 0);
    check("midrst:noferr", n_ferr - f0, 0);
    rx_frame("after_rst", 8'h5A, 1'b1, 4, 1'b0, -1);

    for (int k = 0; k < 5; k++) begin
      rx_frame($sformatf("rnd%0d", k), 8'($urandom), ($urandom_range(0, 3) != 0),
               int'($urandom_range(3, 4)), bit'($urandom_range(0, 1)), -1);
    end

    check("no_perr", n_perr, 0);
    check("no_both", n_both, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
